// File: rtl/conv_encoder_if.sv
// Bit-serial handshake bundle between an info-bit source, the (7,5) encoder and the viterbi-side consumer.
interface conv_encoder_if;
    logic din;
    logic din_valid;
    logic din_last;
    logic din_ready;
    logic code_out;
    logic code_valid;
    logic code_sync;
    logic busy;

    modport master (
        output din, din_valid, din_last,
        input  din_ready, code_out, code_valid, code_sync, busy
    );

    modport slave (
        input  din, din_valid, din_last,
        output din_ready, code_out, code_valid, code_sync, busy
    );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 (7,5 octal) convolutional encoder, serializing each info bit as a G0/G1 pair, one code bit per clock.
// CONV_TAIL_FLUSH_EN: on din_last, append two zero tail bits and return the trellis to state 00.
module conv_encoder (
    input  logic          clk,
    input  logic          reset,
    conv_encoder_if.slave enc
);
    typedef enum logic [2:0] {IDLE, G0, G1, T0, T1} state_t;

    state_t r_state;
    logic   r_p1;
    logic   r_p2;
    logic   r_c1;
    logic   r_last;
    logic   r_tail_idx;
    logic   r_code_out;
    logic   r_code_valid;
    logic   r_code_sync;
    logic   r_din_ready;
    logic   r_busy;

    logic   w_accept;
    logic   w_c0;
    logic   w_c1;
    logic   w_last;

    assign w_accept = enc.din_valid & r_din_ready;
    assign w_c0     = enc.din ^ r_p1 ^ r_p2;
    assign w_c1     = enc.din ^ r_p2;

`ifdef CONV_TAIL_FLUSH_EN
    assign w_last = enc.din_last;
`else
    // Continuous stream: frame boundaries carry no meaning for the trellis.
    logic w_unused_last;
    assign w_unused_last = enc.din_last;
    assign w_last        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_p1         <= 1'b0;
            r_p2         <= 1'b0;
            r_c1         <= 1'b0;
            r_last       <= 1'b0;
            r_tail_idx   <= 1'b0;
            r_code_out   <= 1'b0;
            r_code_valid <= 1'b0;
            r_code_sync  <= 1'b0;
            r_din_ready  <= 1'b1;
            r_busy       <= 1'b0;
        end else if (w_accept) begin
            // Only possible from IDLE or from G1 with no tail pending.
            r_state      <= G0;
            r_p1         <= enc.din;
            r_p2         <= r_p1;
            r_c1         <= w_c1;
            r_last       <= w_last;
            r_code_out   <= w_c0;
            r_code_valid <= 1'b1;
            r_code_sync  <= 1'b1;
            r_din_ready  <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                end
                G0: begin
                    r_state     <= G1;
                    r_code_out  <= r_c1;
                    r_code_sync <= 1'b0;
                    r_din_ready <= ~r_last;
                end
                G1: begin
                    if (r_last) begin
                        r_state     <= T0;
                        r_last      <= 1'b0;
                        r_tail_idx  <= 1'b0;
                        r_code_out  <= r_p1 ^ r_p2;
                        r_c1        <= r_p2;
                        r_p1        <= 1'b0;
                        r_p2        <= r_p1;
                        r_code_sync <= 1'b1;
                    end else begin
                        r_state      <= IDLE;
                        r_code_out   <= 1'b0;
                        r_code_valid <= 1'b0;
                        r_code_sync  <= 1'b0;
                        r_din_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                T0: begin
                    r_state     <= T1;
                    r_code_out  <= r_c1;
                    r_code_sync <= 1'b0;
                end
                T1: begin
                    if (!r_tail_idx) begin
                        r_state     <= T0;
                        r_tail_idx  <= 1'b1;
                        r_code_out  <= r_p1 ^ r_p2;
                        r_c1        <= r_p2;
                        r_p1        <= 1'b0;
                        r_p2        <= r_p1;
                        r_code_sync <= 1'b1;
                    end else begin
                        r_state      <= IDLE;
                        r_p1         <= 1'b0;
                        r_p2         <= 1'b0;
                        r_code_out   <= 1'b0;
                        r_code_valid <= 1'b0;
                        r_code_sync  <= 1'b0;
                        r_din_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_code_out   <= 1'b0;
                    r_code_valid <= 1'b0;
                    r_code_sync  <= 1'b0;
                    r_din_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign enc.din_ready  = r_din_ready;
    assign enc.code_out   = r_code_out;
    assign enc.code_valid = r_code_valid;
    assign enc.code_sync  = r_code_sync;
    assign enc.busy       = r_busy;
endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: vector tables, hand-written corner sequences and a random stream vs a (7,5) model.
module tb_conv_encoder;
    logic clk;
    logic reset;

    conv_encoder_if bus();

    conv_encoder dut (
        .clk   (clk),
        .reset (reset),
        .enc   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic din;
        logic vld;
        logic last;
        logic out;
        logic valid;
        logic sync;
        logic rdy;
    } vec_t;

    vec_t vt[16];
    int   nv;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rb[1000];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic o, input logic v, input logic s, input logic r);
        check({name, ".code_out"},   bus.code_out,   o);
        check({name, ".code_valid"}, bus.code_valid, v);
        check({name, ".code_sync"},  bus.code_sync,  s);
        check({name, ".busy"},       bus.busy,       v);
        check({name, ".din_ready"},  bus.din_ready,  r);
    endtask

    task automatic add(input logic d, input logic v, input logic l,
                       input logic o, input logic va, input logic s, input logic r);
        vt[nv] = '{d, v, l, o, va, s, r};
        nv++;
    endtask

    task automatic step(input logic d, input logic v, input logic l);
        bus.din       = d;
        bus.din_valid = v;
        bus.din_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_table(input string name);
        do_reset();
        for (int i = 0; i < nv; i++) begin
            step(vt[i].din, vt[i].vld, vt[i].last);
            check_outs($sformatf("%s[%0d]", name, i), vt[i].out, vt[i].valid, vt[i].sync, vt[i].rdy);
        end
    endtask

    // Reference: code pair k/2 from the info-bit sequence, zero history before the first bit.
    function automatic logic exp_code(input int k);
        int   i;
        logic u, a, b;
        i = k / 2;
        u = rb[i];
        a = (i >= 1) ? rb[i-1] : 1'b0;
        b = (i >= 2) ? rb[i-2] : 1'b0;
        return (k % 2 == 0) ? (u ^ a ^ b) : (u ^ b);
    endfunction

    initial begin
        int   idx;
        logic acc;

        reset         = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
        #3;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Frame 1,0,1,1 with din_last on the 4th bit; each bit is held until accepted.
        nv = 0;
        add(1,1,0, 1,1,1,0);
        add(0,1,0, 1,1,0,1);
        add(0,1,0, 1,1,1,0);
        add(1,1,0, 0,1,0,1);
        add(1,1,0, 0,1,1,0);
        add(1,1,1, 0,1,0,1);
        add(1,1,1, 0,1,1,0);
`ifdef CONV_TAIL_FLUSH_EN
        add(0,0,0, 1,1,0,0);
        add(0,0,0, 0,1,1,0);
        add(0,0,0, 1,1,0,0);
        add(0,0,0, 1,1,1,0);
        add(0,0,0, 1,1,0,0);
        add(0,0,0, 0,0,0,1);
        add(0,0,0, 0,0,0,1);
`else
        add(0,0,0, 1,1,0,1);
        add(0,0,0, 0,0,0,1);
        add(0,1,0, 0,1,1,0);
        add(0,0,0, 1,1,0,1);
        add(0,0,0, 0,0,0,1);
`endif
        run_table("frame");

        // Next bit held valid right behind a din_last bit.
        nv = 0;
`ifdef CONV_TAIL_FLUSH_EN
        add(1,1,1, 1,1,1,0);
        add(1,1,0, 1,1,0,0);
        add(1,1,0, 1,1,1,0);
        add(1,1,0, 0,1,0,0);
        add(1,1,0, 1,1,1,0);
        add(1,1,0, 1,1,0,0);
        add(1,1,0, 0,0,0,1);
        add(1,1,0, 1,1,1,0);
        add(0,0,0, 1,1,0,1);
        add(0,0,0, 0,0,0,1);
`else
        add(1,1,1, 1,1,1,0);
        add(1,1,0, 1,1,0,1);
        add(1,1,0, 0,1,1,0);
        add(0,0,0, 1,1,0,1);
        add(0,0,0, 0,0,0,1);
`endif
        run_table("hold");

        // Gap: bit 1, three idle cycles, bit 0 encoded from retained state 10.
        do_reset();
        step(1, 1, 0); check_outs("gap_c0a", 1, 1, 1, 0);
        step(0, 0, 0); check_outs("gap_c1a", 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            check_outs($sformatf("gap_idle%0d", i), 0, 0, 0, 1);
        end
        step(0, 1, 0); check_outs("gap_c0b", 1, 1, 1, 0);
        step(0, 0, 0); check_outs("gap_c1b", 0, 1, 0, 1);

        // Asynchronous reset in G1 with state 11, then restart from 00.
        do_reset();
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0); check_outs("pre_rst_g0", 0, 1, 1, 0);
        step(0, 0, 0); check_outs("pre_rst_g1", 1, 1, 0, 1);
        #2 reset = 1'b1;
        #1 check_outs("async_rst", 0, 0, 0, 1);
        #1 reset = 1'b0;
        step(1, 1, 0); check_outs("post_rst_c0", 1, 1, 1, 0);
        step(0, 0, 0); check_outs("post_rst_c1", 1, 1, 0, 1);

        // 1000 random bits offered continuously.
        for (int i = 0; i < 1000; i++) rb[i] = 1'($urandom_range(1, 0));
        do_reset();
        idx = 0;
        for (int cyc = 0; cyc < 2002; cyc++) begin
            bus.din       = (idx < 1000) ? rb[idx] : 1'b0;
            bus.din_valid = (idx < 1000);
            bus.din_last  = 1'b0;
            acc = bus.din_valid & bus.din_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (cyc < 2000) begin
                check($sformatf("rnd_out[%0d]", cyc),   bus.code_out,   exp_code(cyc));
                check($sformatf("rnd_valid[%0d]", cyc), bus.code_valid, 1'b1);
                check($sformatf("rnd_sync[%0d]", cyc),  bus.code_sync,  (cyc % 2 == 0));
            end
        end
        check_int("rnd_accepted", idx, 1000);
        check("rnd_end_valid", bus.code_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
